rr_sel_arbiter4: RTL and testbench

- Four-channel round-robin arbiter with burst hold. It generates the 2-bit select that drives the downstream 4:1 data mux: sel[1] feeds s1 and sel[0] feeds s0.
- Channel data a, b, c and d map to channel indices 0, 1, 2 and 3.
- It sits directly upstream of the mux. It converts per-channel requests into a stable select plus a valid/ready beat handshake toward the consumer of the mux output.

---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/rr_sel_arbiter4.sv | 104 ++++++++++
 tb/tb_rr_sel_arbiter4.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 4-channel
// round-robin select arbiter.
package rr_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping
// modulo 4. Rotate, priority-encode, un-rotate.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [SEL_W-1:0]    off;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_CH-1:0];
        off = '0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign found = |req;
    assign idx   = ptr + off;

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Four-channel round-robin arbiter with burst hold; drives the {s1,s0} select
// of a downstream 4:1 mux plus a valid/ready beat handshake.
module rr_sel_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] gnt,
    output logic              out_valid,
    output logic [CNT_W-1:0]  beat_cnt
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              busy, xfer, last_beat, rel;
    logic [SEL_W-1:0]  pick_ptr, pick_idx;
    logic              pick_found;

    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req[sel_q];
    assign xfer      = out_valid & out_ready;
    assign last_beat = (cnt_q == CNT_W'(BURST - 1));
    // A dropped request releases without a transfer since out_valid is already low.
    assign rel       = busy & ((xfer & last_beat) | ~req[sel_q]);
    assign pick_ptr  = rel ? sel_q + 2'd1 : ptr_q;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot4(pick_idx);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = '0;
                    if (pick_found) begin
                        sel_d = pick_idx;
                        gnt_d = onehot4(pick_idx);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench for rr_sel_arbiter4: three instances (BURST=4,1,2) share
// stimulus; directed vector table, a reset-mid-grant sequence, random vs model.
module tb_rr_sel_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;

    logic [1:0] sel_o   [3];
    logic [3:0] gnt_o   [3];
    logic       valid_o [3];
    logic [1:0] cnt_o   [3];
    logic [1:0] cnt_b4;
    logic       cnt_b1, cnt_b2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter4 #(.BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .sel(sel_o[0]), .gnt(gnt_o[0]), .out_valid(valid_o[0]), .beat_cnt(cnt_b4)
    );
    rr_sel_arbiter4 #(.BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .sel(sel_o[1]), .gnt(gnt_o[1]), .out_valid(valid_o[1]), .beat_cnt(cnt_b1)
    );
    rr_sel_arbiter4 #(.BURST(2)) u_b2 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .sel(sel_o[2]), .gnt(gnt_o[2]), .out_valid(valid_o[2]), .beat_cnt(cnt_b2)
    );

    assign cnt_o[0] = cnt_b4;
    assign cnt_o[1] = {1'b0, cnt_b1};
    assign cnt_o[2] = {1'b0, cnt_b2};

    // Reference model: which channel owns the mux, beats taken, next priority.
    int m_burst [3];
    int m_owner [3];
    int m_cnt   [3];
    int m_ptr   [3];
    int m_sel   [3];

    function automatic int first_req(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owner[i] = -1;
            m_cnt[i]   = 0;
            m_ptr[i]   = 0;
            m_sel[i]   = 0;
        end
    endtask

    task automatic model_step(logic [3:0] r, logic rdy);
        for (int i = 0; i < 3; i++) begin
            int w;
            bit x;
            if (m_owner[i] < 0) begin
                w = first_req(r, m_ptr[i]);
                if (w >= 0) begin
                    m_owner[i] = w;
                    m_sel[i]   = w;
                    m_cnt[i]   = 0;
                end
            end else begin
                x = r[m_owner[i]] && rdy;
                if ((x && m_cnt[i] == m_burst[i] - 1) || !r[m_owner[i]]) begin
                    m_ptr[i]   = (m_owner[i] + 1) % 4;
                    m_cnt[i]   = 0;
                    w          = first_req(r, m_ptr[i]);
                    m_owner[i] = w;
                    if (w >= 0) m_sel[i] = w;
                end else if (x) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(int i, string tag);
        logic [3:0] eg;
        logic       ev;
        eg = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        ev = (m_owner[i] >= 0) && req[m_owner[i]];
        check($sformatf("%s.sel[%0d]", tag, i), 32'(sel_o[i]), 32'(m_sel[i]));
        check($sformatf("%s.gnt[%0d]", tag, i), 32'(gnt_o[i]), 32'(eg));
        check($sformatf("%s.valid[%0d]", tag, i), 32'(valid_o[i]), 32'(ev));
        check($sformatf("%s.cnt[%0d]", tag, i), 32'(cnt_o[i]), 32'(m_cnt[i]));
    endtask

    // Called at a negedge: asserts reset between edges and checks it acts at once.
    task automatic reset_pulse(string tag);
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.rst_sel[%0d]", tag, i), 32'(sel_o[i]), 32'd0);
            check($sformatf("%s.rst_gnt[%0d]", tag, i), 32'(gnt_o[i]), 32'd0);
            check($sformatf("%s.rst_valid[%0d]", tag, i), 32'(valid_o[i]), 32'd0);
            check($sformatf("%s.rst_cnt[%0d]", tag, i), 32'(cnt_o[i]), 32'd0);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step(req, out_ready);
        @(negedge clk);
    endtask

    typedef struct {
        bit         do_rst;
        int         inst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit r, int inst, logic [3:0] q, logic rdy,
                       logic [1:0] s, logic [3:0] g, logic v, logic [1:0] c);
        vec_t e;
        e.do_rst = r; e.inst = inst; e.req = q; e.rdy = rdy;
        e.sel = s; e.gnt = g; e.vld = v; e.cnt = c;
        vecs.push_back(e);
    endtask

    initial begin
        m_burst[0] = 4; m_burst[1] = 1; m_burst[2] = 2;
        rst = 1'b1; req = '0; out_ready = 1'b0;
        model_reset();

        // Single-channel burst (BURST=4): 4 beats, then back-to-back re-grant.
        add(1, 0, 4'b0100, 1, 2'b00, 4'b0000, 0, 0);
        add(0, 0, 4'b0100, 1, 2'b10, 4'b0100, 1, 0);
        add(0, 0, 4'b0100, 1, 2'b10, 4'b0100, 1, 1);
        add(0, 0, 4'b0100, 1, 2'b10, 4'b0100, 1, 2);
        add(0, 0, 4'b0100, 1, 2'b10, 4'b0100, 1, 3);
        add(0, 0, 4'b0100, 1, 2'b10, 4'b0100, 1, 0);
        // Backpressure: grant and count frozen while out_ready=0.
        add(1, 0, 4'b0010, 0, 2'b00, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 4'b0010, 0, 2'b01, 4'b0010, 1, 0);
        add(0, 0, 4'b0010, 1, 2'b01, 4'b0010, 1, 0);
        add(0, 0, 4'b0010, 1, 2'b01, 4'b0010, 1, 1);
        add(0, 0, 4'b0010, 1, 2'b01, 4'b0010, 1, 2);
        // Full rotation (BURST=1).
        add(1, 1, 4'b1111, 1, 2'b00, 4'b0000, 0, 0);
        add(0, 1, 4'b1111, 1, 2'b00, 4'b0001, 1, 0);
        add(0, 1, 4'b1111, 1, 2'b01, 4'b0010, 1, 0);
        add(0, 1, 4'b1111, 1, 2'b10, 4'b0100, 1, 0);
        add(0, 1, 4'b1111, 1, 2'b11, 4'b1000, 1, 0);
        add(0, 1, 4'b1111, 1, 2'b00, 4'b0001, 1, 0);
        // Early drop on ch3 mid-burst, pointer wraps to ch0.
        add(1, 0, 4'b1000, 1, 2'b00, 4'b0000, 0, 0);
        add(0, 0, 4'b1000, 1, 2'b11, 4'b1000, 1, 0);
        add(0, 0, 4'b0001, 1, 2'b11, 4'b1000, 0, 1);
        add(0, 0, 4'b0001, 1, 2'b00, 4'b0001, 1, 0);
        // Fairness (BURST=2): ch0 and ch3 alternate, 2 beats each.
        add(1, 2, 4'b1001, 1, 2'b00, 4'b0000, 0, 0);
        for (int k = 0; k < 2; k++) begin
            add(0, 2, 4'b1001, 1, 2'b00, 4'b0001, 1, 0);
            add(0, 2, 4'b1001, 1, 2'b00, 4'b0001, 1, 1);
            add(0, 2, 4'b1001, 1, 2'b11, 4'b1000, 1, 0);
            add(0, 2, 4'b1001, 1, 2'b11, 4'b1000, 1, 1);
        end

        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            vec_t e;
            string t;
            e = vecs[n];
            t = $sformatf("vec%0d", n);
            if (e.do_rst) reset_pulse(t);
            req       = e.req;
            out_ready = e.rdy;
            #1;
            check({t, ".sel"},   32'(sel_o[e.inst]),   32'(e.sel));
            check({t, ".gnt"},   32'(gnt_o[e.inst]),   32'(e.gnt));
            check({t, ".valid"}, 32'(valid_o[e.inst]), 32'(e.vld));
            check({t, ".cnt"},   32'(cnt_o[e.inst]),   32'(e.cnt));
            edge_step();
        end

        // Reset mid-grant: ch2 holding with beat_cnt=2, then async reset.
        reset_pulse("rstmid.init");
        req = 4'b0100; out_ready = 1'b1;
        edge_step();
        edge_step();
        edge_step();
        #1;
        check("rstmid.cnt_before", 32'(cnt_o[0]), 32'd2);
        check("rstmid.sel_before", 32'(sel_o[0]), 32'd2);
        reset_pulse("rstmid");
        edge_step();
        #1;
        check("rstmid.sel_after", 32'(sel_o[0]), 32'd2);
        check("rstmid.gnt_after", 32'(gnt_o[0]), 32'b0100);
        check("rstmid.cnt_after", 32'(cnt_o[0]), 32'd0);
        check("rstmid.valid_after", 32'(valid_o[0]), 32'd1);
        edge_step();

        // Random traffic against the model on all three instances.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse("rand");
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            for (int i = 0; i < 3; i++) check_model(i, "rand");
            edge_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
